pc_fetch_sequencer: RTL and testbench

Program-counter register and fetch sequencer that drives the single-cycle R-format datapath. Holds the current instruction address, presents it to the datapath's instruction address input, and loads the datapath's PC+4 result back when it advances. Adds run/idle control, stall and single-step support, end-of-program detection, misalignment trapping and a retired-instruction counter for bench and debug use.

---
 rtl/pc_fetch_sequencer_if.sv | 27 ++
 rtl/pc_fetch_sequencer.sv | 105 ++++++++++
 tb/tb_pc_fetch_sequencer.sv | 335 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer and whoever controls it: run/stall/step
// controls and the datapath's PC+4 in, instruction address, commit and status out.
interface pc_fetch_sequencer_if #(
   parameter int CNT_W = 16
) ();
   logic             start;
   logic             stall;
   logic             step_mode;
   logic             step;
   logic [31:0]      next_addr;
   logic [31:0]      pc_addr;
   logic             commit;
   logic             busy;
   logic             done;
   logic             err;
   logic [CNT_W-1:0] instr_count;

   modport master (
      output start, stall, step_mode, step, next_addr,
      input  pc_addr, commit, busy, done, err, instr_count
   );

   modport slave (
      input  start, stall, step_mode, step, next_addr,
      output pc_addr, commit, busy, done, err, instr_count
   );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter and fetch sequencer for the single-cycle datapath: run/idle
// control, stall and single-step, end-of-program detection, misalignment trap.
module pc_fetch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] END_PC   = 32'h0000_007C,
   parameter int          CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   pc_fetch_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10,
      ST_ERR  = 2'b11
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_e           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             advance_s;

   // Retire condition; stall wins over a coincident step, which is then lost.
   assign advance_s = (state_q == ST_RUN) & ~bus.stall & (~bus.step_mode | bus.step);

   // Next-state, next-PC and retired-count logic.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (bus.start) begin
               state_d = ST_RUN;
               pc_d    = RESET_PC;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               state_d = state_q;
            end
         end
         ST_RUN: begin
            if (advance_s) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_ONE;
               end else begin
                  cnt_d = cnt_q;
               end
               // The faulting PC+4 is never loaded, so pc_addr still names the bad instruction.
               if (pc_q == END_PC) begin
                  state_d = ST_DONE;
               end else if (bus.next_addr[1:0] != 2'b00) begin
                  state_d = ST_ERR;
               end else begin
                  pc_d = bus.next_addr;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            pc_d    = RESET_PC;
            cnt_d   = {CNT_W{1'b0}};
         end
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_DONE);
      err_d  = (state_d == ST_ERR);
   end

   // State, PC, counter and status flags; reset aborts a run without waiting for a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         cnt_q   <= {CNT_W{1'b0}};
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.pc_addr     = pc_q;
   assign bus.commit      = advance_s;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.err         = err_q;
   assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Bench for pc_fetch_sequencer: directed scenarios plus randomized control against
// a run/retire reference model; a second instance covers address wrap and count saturation.
module tb_pc_fetch_sequencer;

   localparam logic [31:0] A_RESET = 32'h0000_0000;
   localparam logic [31:0] A_END   = 32'h0000_000C;
   localparam logic [31:0] B_RESET = 32'hFFFF_FFF8;
   localparam logic [31:0] B_END   = 32'h0000_0004;

   // model run phases
   localparam int M_IDLE = 0;
   localparam int M_RUN  = 1;
   localparam int M_DONE = 2;
   localparam int M_ERR  = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   int          m_st;
   logic [31:0] m_pc;
   logic [15:0] m_cnt;

   logic [31:0] exp_b [4];

   always #5 clk = ~clk;

   pc_fetch_sequencer_if #(.CNT_W(16)) a_if ();
   pc_fetch_sequencer_if #(.CNT_W(2))  b_if ();

   pc_fetch_sequencer #(.RESET_PC(A_RESET), .END_PC(A_END), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(a_if.slave)
   );
   pc_fetch_sequencer #(.RESET_PC(B_RESET), .END_PC(B_END), .CNT_W(2)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(b_if.slave)
   );

   task automatic model_reset();
      m_st  = M_IDLE;
      m_pc  = A_RESET;
      m_cnt = 16'd0;
   endtask

   function automatic logic model_adv();
      return (m_st == M_RUN) && !a_if.stall && (!a_if.step_mode || a_if.step);
   endfunction

   task automatic drive_a(input logic st, input logic sl, input logic sm,
                          input logic sp, input logic [31:0] na);
      @(negedge clk);
      a_if.start     = st;
      a_if.stall     = sl;
      a_if.step_mode = sm;
      a_if.step      = sp;
      a_if.next_addr = na;
      #1;
   endtask

   task automatic tick_a();
      logic adv;
      adv = model_adv();
      @(posedge clk);
      if (m_st != M_RUN) begin
         if (a_if.start) begin
            m_st  = M_RUN;
            m_pc  = A_RESET;
            m_cnt = 16'd0;
         end
      end else if (adv) begin
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
         if (m_pc == A_END)                    m_st = M_DONE;
         else if (a_if.next_addr[1:0] != 2'b00) m_st = M_ERR;
         else                                  m_pc = a_if.next_addr;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      a_if.start = 1'b0; a_if.stall = 1'b0; a_if.step_mode = 1'b0; a_if.step = 1'b0;
      a_if.next_addr = 32'h0000_0004;
      b_if.start = 1'b0; b_if.stall = 1'b0; b_if.step_mode = 1'b0; b_if.step = 1'b0;
      b_if.next_addr = 32'h0000_0000;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (a_if.pc_addr !== 32'h0000_0000 || a_if.instr_count !== 16'd0) begin
         errors++; $display("FAIL reset_a pc=%h cnt=%0d required pc=0 cnt=0", a_if.pc_addr, a_if.instr_count);
      end
      checks++;
      if ({a_if.busy, a_if.done, a_if.err, a_if.commit} !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got %b required 0000", {a_if.busy, a_if.done, a_if.err, a_if.commit});
      end
      checks++;
      if (b_if.pc_addr !== 32'hFFFF_FFF8 || b_if.instr_count !== 2'd0) begin
         errors++; $display("FAIL reset_b pc=%h cnt=%0d required pc=fffffff8 cnt=0", b_if.pc_addr, b_if.instr_count);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_run_to_completion();
      int ncommit;
      ncommit = 0;
      drive_a(1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      checks++;
      if (a_if.commit !== 1'b0) begin
         errors++; $display("FAIL idle_commit got %b required 0", a_if.commit);
      end
      tick_a();
      checks++;
      if (a_if.busy !== 1'b1 || a_if.pc_addr !== 32'h0) begin
         errors++; $display("FAIL start busy=%b pc=%h required busy=1 pc=0", a_if.busy, a_if.pc_addr);
      end
      for (int i = 0; i < 4; i++) begin
         drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
         checks++;
         if (a_if.pc_addr !== 32'(i * 4)) begin
            errors++; $display("FAIL run_pc step %0d got %h required %h", i, a_if.pc_addr, 32'(i * 4));
         end
         if (a_if.commit === 1'b1) ncommit++;
         tick_a();
      end
      checks++;
      if (ncommit != 4) begin
         errors++; $display("FAIL run_commits got %0d required 4", ncommit);
      end
      checks++;
      if (a_if.done !== 1'b1 || a_if.busy !== 1'b0 || a_if.instr_count !== 16'd4 || a_if.pc_addr !== 32'h0000_000C) begin
         errors++; $display("FAIL run_end done=%b busy=%b cnt=%0d pc=%h required done=1 busy=0 cnt=4 pc=0000000c",
                            a_if.done, a_if.busy, a_if.instr_count, a_if.pc_addr);
      end
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      tick_a();
      checks++;
      if (a_if.commit !== 1'b0 || a_if.pc_addr !== 32'h0000_000C || a_if.done !== 1'b1) begin
         errors++; $display("FAIL done_hold commit=%b pc=%h done=%b required 0 0000000c 1", a_if.commit, a_if.pc_addr, a_if.done);
      end
   endtask

   task automatic test_stall();
      int cyc;
      drive_a(1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      tick_a();
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      tick_a();
      for (int i = 0; i < 3; i++) begin
         drive_a(1'b0, 1'b1, 1'b0, 1'b0, m_pc + 32'd4);
         checks++;
         if (a_if.commit !== 1'b0 || a_if.pc_addr !== 32'h4) begin
            errors++; $display("FAIL stall_hold cycle %0d commit=%b pc=%h required 0 00000004", i, a_if.commit, a_if.pc_addr);
         end
         tick_a();
      end
      cyc = 0;
      while (a_if.done !== 1'b1 && cyc < 20) begin
         drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
         tick_a();
         cyc++;
      end
      checks++;
      if (cyc != 3 || a_if.instr_count !== 16'd4) begin
         errors++; $display("FAIL stall_done cycles=%0d cnt=%0d required cycles=3 cnt=4", cyc, a_if.instr_count);
      end
   endtask

   task automatic test_step_mode();
      int  cyc;
      logic sp, sl;
      drive_a(1'b1, 1'b0, 1'b1, 1'b0, m_pc + 32'd4);
      tick_a();
      for (int c = 0; c < 7; c++) begin
         sp = (c == 2) || (c == 3) || (c == 5);
         sl = (c == 3);
         drive_a(1'b0, sl, 1'b1, sp, m_pc + 32'd4);
         checks++;
         if (a_if.commit !== model_adv() || a_if.pc_addr !== m_pc) begin
            errors++; $display("FAIL step_cycle %0d commit=%b pc=%h required %b %h", c, a_if.commit, a_if.pc_addr, model_adv(), m_pc);
         end
         tick_a();
      end
      checks++;
      if (a_if.pc_addr !== 32'h8 || a_if.instr_count !== 16'd2 || a_if.busy !== 1'b1) begin
         errors++; $display("FAIL step_end pc=%h cnt=%0d busy=%b required 00000008 2 1", a_if.pc_addr, a_if.instr_count, a_if.busy);
      end
      cyc = 0;
      while (a_if.done !== 1'b1 && cyc < 20) begin
         drive_a(1'b0, 1'b0, 1'b0, 1'b1, m_pc + 32'd4);
         tick_a();
         cyc++;
      end
      checks++;
      if (cyc != 2) begin
         errors++; $display("FAIL step_finish cycles=%0d required 2", cyc);
      end
   endtask

   task automatic test_misaligned();
      drive_a(1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      tick_a();
      repeat (2) begin
         drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
         tick_a();
      end
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_000E);
      checks++;
      if (a_if.commit !== 1'b1 || a_if.pc_addr !== 32'h8) begin
         errors++; $display("FAIL mis_commit commit=%b pc=%h required 1 00000008", a_if.commit, a_if.pc_addr);
      end
      tick_a();
      checks++;
      if (a_if.err !== 1'b1 || a_if.busy !== 1'b0 || a_if.pc_addr !== 32'h8 || a_if.instr_count !== 16'd3) begin
         errors++; $display("FAIL mis_trap err=%b busy=%b pc=%h cnt=%0d required 1 0 00000008 3",
                            a_if.err, a_if.busy, a_if.pc_addr, a_if.instr_count);
      end
      drive_a(1'b1, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      tick_a();
      checks++;
      if (a_if.busy !== 1'b1 || a_if.err !== 1'b0 || a_if.pc_addr !== 32'h0 || a_if.instr_count !== 16'd0) begin
         errors++; $display("FAIL mis_restart busy=%b err=%b pc=%h cnt=%0d required 1 0 00000000 0",
                            a_if.busy, a_if.err, a_if.pc_addr, a_if.instr_count);
      end
   endtask

   task automatic test_reset_mid_run();
      repeat (2) begin
         drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
         tick_a();
      end
      drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
      checks++;
      if (a_if.pc_addr !== 32'h8 || a_if.commit !== 1'b1) begin
         errors++; $display("FAIL pre_abort pc=%h commit=%b required 00000008 1", a_if.pc_addr, a_if.commit);
      end
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (a_if.pc_addr !== 32'h0 || a_if.instr_count !== 16'd0 || a_if.busy !== 1'b0 || a_if.commit !== 1'b0) begin
         errors++; $display("FAIL async_abort pc=%h cnt=%0d busy=%b commit=%b required 0 0 0 0",
                            a_if.pc_addr, a_if.instr_count, a_if.busy, a_if.commit);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         drive_a(1'b0, 1'b0, 1'b0, 1'b0, m_pc + 32'd4);
         tick_a();
      end
      checks++;
      if (a_if.busy !== 1'b0 || a_if.pc_addr !== 32'h0 || a_if.commit !== 1'b0) begin
         errors++; $display("FAIL idle_after_abort busy=%b pc=%h commit=%b required 0 0 0", a_if.busy, a_if.pc_addr, a_if.commit);
      end
   endtask

   task automatic test_wrap_saturation();
      int ncommit;
      exp_b[0] = 32'hFFFF_FFF8; exp_b[1] = 32'hFFFF_FFFC;
      exp_b[2] = 32'h0000_0000; exp_b[3] = 32'h0000_0004;
      ncommit = 0;
      @(negedge clk);
      b_if.start = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (b_if.busy !== 1'b1 || b_if.pc_addr !== B_RESET) begin
         errors++; $display("FAIL wrap_start busy=%b pc=%h required 1 fffffff8", b_if.busy, b_if.pc_addr);
      end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_if.start     = 1'b0;
         b_if.next_addr = exp_b[i] + 32'd4;
         #1;
         checks++;
         if (b_if.pc_addr !== exp_b[i] || b_if.instr_count !== 2'((i > 3) ? 3 : i)) begin
            errors++; $display("FAIL wrap_step %0d pc=%h cnt=%0d required %h %0d", i, b_if.pc_addr, b_if.instr_count, exp_b[i], i);
         end
         if (b_if.commit === 1'b1) ncommit++;
         @(posedge clk);
         #1;
      end
      checks++;
      if (ncommit != 4 || b_if.done !== 1'b1 || b_if.instr_count !== 2'd3 || b_if.pc_addr !== 32'h4) begin
         errors++; $display("FAIL wrap_end commits=%0d done=%b cnt=%0d pc=%h required 4 1 3 00000004",
                            ncommit, b_if.done, b_if.instr_count, b_if.pc_addr);
      end
   endtask

   task automatic test_random();
      logic st, sl, sm, sp;
      logic [31:0] na;
      int r;
      for (int c = 0; c < 400; c++) begin
         st = ($urandom % 6) == 0;
         sl = ($urandom % 4) == 0;
         sm = ($urandom % 3) == 0;
         sp = ($urandom % 2) == 0;
         r  = $urandom % 20;
         na = (r == 0) ? m_pc + 32'd2 : (r == 1) ? m_pc + 32'd5 : m_pc + 32'd4;
         drive_a(st, sl, sm, sp, na);
         checks++;
         if (a_if.commit !== model_adv()) begin
            errors++; $display("FAIL rand_commit cycle %0d got %b required %b", c, a_if.commit, model_adv());
         end
         tick_a();
         checks++;
         if (a_if.pc_addr !== m_pc || a_if.instr_count !== m_cnt ||
             a_if.busy !== (m_st == M_RUN) || a_if.done !== (m_st == M_DONE) || a_if.err !== (m_st == M_ERR)) begin
            errors++; $display("FAIL rand_state cycle %0d pc=%h cnt=%0d bde=%b%b%b required pc=%h cnt=%0d phase=%0d",
                               c, a_if.pc_addr, a_if.instr_count, a_if.busy, a_if.done, a_if.err, m_pc, m_cnt, m_st);
         end
      end
   endtask

   initial begin
      test_reset();
      test_run_to_completion();
      test_stall();
      test_step_mode();
      test_misaligned();
      test_reset_mid_run();
      test_wrap_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
